// File: rtl/mem_requester_if.sv
// Request, response and memory-port signals of mem_requester.
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// While req_valid is high and req_ready is low, the initiator holds req_write,
// req_addr and req_wdata unchanged. rsp_valid is a one-cycle pulse with no
// ready: the consumer samples rsp_write/rsp_rdata in that cycle.
interface mem_requester_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_rdata;

  logic              mem_writeEn;
  logic [ADDR_W-1:0] mem_tagIn;
  logic [DATA_W-1:0] mem_dataIn;
  logic [DATA_W-1:0] mem_dataOut;

  // Requester view (the block itself).
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_dataOut,
    output req_ready, rsp_valid, rsp_write, rsp_rdata,
    output mem_writeEn, mem_tagIn, mem_dataIn
  );

  // Environment view: cache controller plus memory.
  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_dataOut,
    input  req_ready, rsp_valid, rsp_write, rsp_rdata,
    input  mem_writeEn, mem_tagIn, mem_dataIn
  );
endinterface

// File: rtl/mem_requester.sv
// Cache-side bus initiator: 2-entry request buffer feeding a serialising FSM
// that drives a combinational memory through registered strobes and returns
// one in-order response pulse per request.
module mem_requester #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  mem_requester_if.slave bus,
  output logic       busy,
  output logic [1:0] state_dbg
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam int ENTRY_W = 1 + ADDR_W + DATA_W;

  logic [1:0]         state;
  logic [2:0]         lat_cnt;
  logic [ENTRY_W-1:0] fifo_mem [2];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [1:0]         count;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head;
  logic               head_write;
  logic [ADDR_W-1:0]  head_addr;
  logic [DATA_W-1:0]  head_wdata;

  // Ready depends only on occupancy, never on a same-cycle pop.
  assign bus.req_ready = (count != 2'd2);
  assign push          = bus.req_valid && bus.req_ready;
  assign pop           = (state == IDLE) && (count != 2'd0);

  assign head       = fifo_mem[rd_ptr];
  assign head_write = head[ENTRY_W-1];
  assign head_addr  = head[DATA_W +: ADDR_W];
  assign head_wdata = head[DATA_W-1:0];

  assign busy      = (state != IDLE) || (count != 2'd0);
  assign state_dbg = state;

  // Request buffer: storage, wrapping pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {bus.req_write, bus.req_addr, bus.req_wdata};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Service FSM: one request at a time; memory strobes and responses are
  // registered so the memory and the cache see glitch-free signals.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      lat_cnt         <= 3'd0;
      bus.mem_writeEn <= 1'b0;
      bus.mem_tagIn   <= '0;
      bus.mem_dataIn  <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_write   <= 1'b0;
      bus.rsp_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (count != 2'd0) begin
            // Address and data are only loaded here, so they stay stable for
            // the whole service of a request.
            bus.mem_tagIn  <= head_addr;
            bus.mem_dataIn <= head_wdata;
            if (head_write) begin
              bus.mem_writeEn <= 1'b1;
              state           <= WRITE;
            end else begin
              bus.mem_writeEn <= 1'b0;
              lat_cnt         <= 3'(MEM_LAT - 1);
              state           <= READ;
            end
          end
        end
        WRITE: begin
          bus.mem_writeEn <= 1'b0;
          bus.rsp_rdata   <= '0;
          bus.rsp_valid   <= 1'b1;
          bus.rsp_write   <= 1'b1;
          state           <= RESP;
        end
        READ: begin
          if (lat_cnt == 3'd0) begin
            bus.rsp_rdata <= bus.mem_dataOut;
            bus.rsp_valid <= 1'b1;
            bus.rsp_write <= 1'b0;
            state         <= RESP;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        RESP: begin
          bus.rsp_valid <= 1'b0;
          bus.rsp_write <= 1'b0;
          state         <= IDLE;
        end
        default: begin
          bus.mem_writeEn <= 1'b0;
          bus.rsp_valid   <= 1'b0;
          state           <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_requester.sv
// Randomised and directed bench for mem_requester. A timing/data reference
// model predicts, per accepted request, its pop edge and response cycle from
// the service rules, and a shadow memory predicts read data.
module tb_mem_requester;

  localparam int AW  = 12;
  localparam int DW  = 16;
  localparam int LAT = 2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mem_requester_if #(.ADDR_W(AW), .DATA_W(DW)) bus  ();
  mem_requester_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
  mem_requester_if #(.ADDR_W(AW), .DATA_W(DW)) bus7 ();

  logic       busy, busy1, busy7;
  logic [1:0] st, st1, st7;

  mem_requester #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .state_dbg(st));
  mem_requester #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut_lat1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .busy(busy1), .state_dbg(st1));
  mem_requester #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(7)) dut_lat7 (
    .clk(clk), .rst_n(rst_n), .bus(bus7), .busy(busy7), .state_dbg(st7));

  // ---------------- memory environment ----------------
  logic [DW-1:0] mem [4096];
  logic          mem_init = 1'b1;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 4096; i++) mem[i] <= DW'(i & 8'hFF);
    end else if (bus.mem_writeEn) begin
      mem[bus.mem_tagIn] <= bus.mem_dataIn;
    end
  end

  assign bus.mem_dataOut  = mem[bus.mem_tagIn];
  assign bus1.mem_dataOut = mem[bus1.mem_tagIn];
  assign bus7.mem_dataOut = mem[bus7.mem_tagIn];

  // ---------------- reference model state ----------------
  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            t;   // acceptance edge
    int            p;   // pop edge
    int            r;   // response cycle
  } rec_t;

  rec_t          drive_q[$];
  rec_t          pend_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] obs_q[$];
  int            rsp_cyc_q[$];
  logic [DW-1:0] shadow [4096];

  int            last_r;
  int            last_lat;
  int            gap;
  bit            rnd_gaps;
  bit            prev_valid;
  bit            prev_ready;
  bit            exp_we_now;
  logic [AW-1:0] last_tag;
  logic [DW-1:0] last_data;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // ---------------- driver ----------------
  task automatic drive_next(input bit rdy);
    bit v;
    prev_ready = rdy;
    v = 1'b0;
    if (drive_q.size() > 0 && gap == 0) begin
      v             = 1'b1;
      bus.req_write = drive_q[0].w;
      bus.req_addr  = drive_q[0].a;
      bus.req_wdata = drive_q[0].d;
    end else if (gap > 0) begin
      gap--;
    end
    bus.req_valid = v;
    prev_valid    = v;
  endtask

  task automatic push_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    rec_t r;
    r.w = w; r.a = a; r.d = d; r.t = 0; r.p = 0; r.r = 0;
    drive_q.push_back(r);
  endtask

  // One cycle: resolve acceptance at the last edge, check all outputs
  // against the model, then drive the next request.
  task automatic step();
    rec_t r;
    int   k;
    int   cnt;
    bit   exp_busy;
    @(negedge clk);
    k = cyc;
    if (prev_valid && prev_ready) begin
      r   = drive_q.pop_front();
      r.t = k;
      r.p = (k + 1 > last_r + 2) ? k + 1 : last_r + 2;
      r.r = r.w ? r.p + 1 : r.p + LAT;
      last_r = r.r;
      if (r.w) begin
        exp_q.push_back('0);
        shadow[r.a] = r.d;
      end else begin
        exp_q.push_back(shadow[r.a]);
      end
      pend_q.push_back(r);
      gap = rnd_gaps ? int'($urandom_range(0, 3)) : 0;
    end
    cnt = 0; exp_busy = 1'b0; exp_we_now = 1'b0;
    foreach (pend_q[i]) begin
      if (pend_q[i].p > k) cnt++;
      if (pend_q[i].p <= k) exp_busy = 1'b1;
      if (pend_q[i].p == k) begin
        last_tag  = pend_q[i].a;
        last_data = pend_q[i].d;
        if (pend_q[i].w) exp_we_now = 1'b1;
      end
    end
    if (cnt > 0) exp_busy = 1'b1;
    check_eq("req_ready",   bus.req_ready,   cnt < 2);
    check_eq("mem_writeEn", bus.mem_writeEn, exp_we_now);
    check_eq("mem_tagIn",   bus.mem_tagIn,   last_tag);
    check_eq("mem_dataIn",  bus.mem_dataIn,  last_data);
    check_eq("busy",        busy,            exp_busy);
    if (pend_q.size() > 0 && pend_q[0].r == k) begin
      check_eq("rsp_valid", bus.rsp_valid, 1'b1);
      check_eq("rsp_write", bus.rsp_write, pend_q[0].w);
      check_eq("rsp_rdata", bus.rsp_rdata, exp_q.pop_front());
      obs_q.push_back(bus.rsp_rdata);
      rsp_cyc_q.push_back(k);
      last_lat = k - pend_q[0].t;
      void'(pend_q.pop_front());
    end else begin
      check_eq("rsp_valid_idle", bus.rsp_valid, 1'b0);
    end
    drive_next(cnt < 2);
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && (drive_q.size() > 0 || pend_q.size() > 0); i++) step();
    check_eq("drain", drive_q.size() + pend_q.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid  = 1'b0; bus.req_write  = 1'b0; bus.req_addr  = '0; bus.req_wdata  = '0;
    bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0;
    bus7.req_valid = 1'b0; bus7.req_write = 1'b0; bus7.req_addr = '0; bus7.req_wdata = '0;
    drive_q.delete(); pend_q.delete(); exp_q.delete();
    last_r = -100; gap = 0; prev_valid = 1'b0; prev_ready = 1'b1;
    last_tag = '0; last_data = '0;
    @(negedge clk);
    check_eq("rst_req_ready", bus.req_ready,   1'b1);
    check_eq("rst_busy",      busy,            1'b0);
    check_eq("rst_writeEn",   bus.mem_writeEn, 1'b0);
    check_eq("rst_rsp_valid", bus.rsp_valid,   1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_next(1'b1);
  endtask

  // Directed read on the MEM_LAT=1 and MEM_LAT=7 instances in parallel.
  task automatic lat_test(input logic [AW-1:0] a);
    int            k1, k7, n1, n7;
    logic [DW-1:0] e;
    e = shadow[a];
    @(negedge clk);
    check_eq("lat1_ready", bus1.req_ready, 1'b1);
    check_eq("lat7_ready", bus7.req_ready, 1'b1);
    bus1.req_valid = 1'b1; bus1.req_write = 1'b0; bus1.req_addr = a;
    bus7.req_valid = 1'b1; bus7.req_write = 1'b0; bus7.req_addr = a;
    @(negedge clk);
    bus1.req_valid = 1'b0;
    bus7.req_valid = 1'b0;
    k1 = -1; k7 = -1; n1 = 0; n7 = 0;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (k1 < 0) check_eq("lat1_tag", bus1.mem_tagIn, a);
      if (k7 < 0) check_eq("lat7_tag", bus7.mem_tagIn, a);
      if (bus1.rsp_valid) begin
        n1++;
        if (k1 < 0) begin k1 = j; check_eq("lat1_rdata", bus1.rsp_rdata, e); end
      end
      if (bus7.rsp_valid) begin
        n7++;
        if (k7 < 0) begin k7 = j; check_eq("lat7_rdata", bus7.rsp_rdata, e); end
      end
    end
    check_eq("lat1_delay",  k1, 2);
    check_eq("lat7_delay",  k7, 8);
    check_eq("lat1_pulses", n1, 1);
    check_eq("lat7_pulses", n7, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit seen_we;
    rnd_gaps = 1'b0;
    for (int i = 0; i < 4096; i++) shadow[i] = DW'(i & 8'hFF);
    mem_init = 1'b1;
    do_reset();
    mem_init = 1'b0;

    // Single write then read of 0x100.
    obs_q.delete();
    push_req(1'b1, 12'h100, 16'h0123);
    drain();
    push_req(1'b0, 12'h100, 16'h0000);
    drain();
    check_eq("wr_rsp_data", obs_q[0], 16'h0000);
    check_eq("rd_rsp_data", obs_q[1], 16'h0123);
    check_eq("rd_latency",  last_lat, 3);

    // Mixed ordering on 0x110.
    obs_q.delete();
    push_req(1'b0, 12'h110, 16'h0000);
    push_req(1'b1, 12'h110, 16'hBEEF);
    push_req(1'b0, 12'h110, 16'h0000);
    drain();
    check_eq("mix_0", obs_q[0], 16'h0010);
    check_eq("mix_1", obs_q[1], 16'h0000);
    check_eq("mix_2", obs_q[2], 16'hBEEF);

    // Buffer full: three back-to-back writes.
    rsp_cyc_q.delete();
    push_req(1'b1, 12'h108, 16'h1111);
    push_req(1'b1, 12'h110, 16'h2222);
    push_req(1'b1, 12'h118, 16'h3333);
    drain();
    check_eq("full_rsp_count", rsp_cyc_q.size(), 3);
    check_eq("full_space_01", rsp_cyc_q[1] - rsp_cyc_q[0], 3);
    check_eq("full_space_12", rsp_cyc_q[2] - rsp_cyc_q[1], 3);

    // Push on the popping edge: two reads back to back.
    obs_q.delete();
    push_req(1'b0, 12'h108, 16'h0000);
    push_req(1'b0, 12'h118, 16'h0000);
    drain();
    check_eq("pushpop_count", obs_q.size(), 2);

    // Reset during the write strobe.
    push_req(1'b1, 12'h1F0, 16'hA5A5);
    seen_we = 1'b0;
    for (int i = 0; i < 10 && !seen_we; i++) begin
      step();
      seen_we = exp_we_now;
    end
    check_eq("rst_found_we", seen_we, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("async_writeEn", bus.mem_writeEn, 1'b0);
    check_eq("async_rsp",     bus.rsp_valid,   1'b0);
    check_eq("async_busy",    busy,            1'b0);
    check_eq("async_ready",   bus.req_ready,   1'b1);
    do_reset();
    for (int i = 0; i < 4; i++) step();

    // Randomised traffic over a small address window.
    for (int i = 0; i < 150; i++) begin
      push_req(1'($urandom_range(0, 1)), 12'h100 + 12'($urandom_range(0, 31)), 16'($urandom));
    end
    rnd_gaps = 1'b1;
    gap = 0;
    drain();
    rnd_gaps = 1'b0;

    // Read latency at the parameter extremes.
    lat_test(12'h110);
    lat_test(12'h100 + 12'($urandom_range(0, 31)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
